// File: rtl/dspmac_pipe.sv
// dspmac_pipe: two-stage pipelined signed multiply-accumulate unit.
// Stage 1 registers the full-width product, the opcode and operand A.
// Stage 2 applies CLR/MUL/MAC/MSU/LOAD to the accumulator and tracks a sticky overflow flag.
// Optional build macro: DSPMAC_SAT_EN -- clamp the accumulator on MAC/MSU overflow instead of wrapping.
module dspmac_pipe #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [2:0]              opcode,
    input  logic signed [A_W-1:0]   a_bus,
    input  logic signed [B_W-1:0]   b_bus,
    output logic signed [ACC_W-1:0] result,
    output logic                    out_valid,
    output logic                    ovf
);

    localparam int P_W = A_W + B_W;

    // Largest and smallest representable accumulator values, used when saturating.
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_MUL  = 3'b001,
        OP_MAC  = 3'b010,
        OP_NOP  = 3'b011,
        OP_MSU  = 3'b100,
        OP_LOAD = 3'b101
    } opcode_t;

    // The accumulator must hold any single product, otherwise MUL could silently overflow.
    generate
        if (ACC_W < P_W) begin : g_widthCheck
            $error("dspmac_pipe: ACC_W must be at least A_W+B_W");
        end
    endgenerate

    logic signed [P_W-1:0]   r_p1;
    logic [2:0]              r_op1;
    logic signed [A_W-1:0]   r_a1;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;
    logic                    r_outValid;

    logic signed [ACC_W-1:0] w_p;
    logic signed [ACC_W-1:0] w_load;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_ovfDet;
    logic signed [ACC_W-1:0] w_accAddSub;

    // Stage 1: capture product, opcode and operand A; an idle input becomes a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1  <= '0;
            r_op1 <= OP_NOP;
            r_a1  <= '0;
        end else if (in_valid) begin
            r_p1  <= P_W'(a_bus) * P_W'(b_bus);
            r_op1 <= opcode;
            r_a1  <= a_bus;
        end else begin
            r_op1 <= OP_NOP;
        end
    end

    // Sign-extended stage-2 operands and a one-bit-wider add/subtract so overflow shows in the top two bits.
    assign w_p      = ACC_W'(r_p1);
    assign w_load   = ACC_W'(r_a1);
    assign w_sum    = (r_op1 == OP_MSU) ? ((ACC_W+1)'(r_acc) - (ACC_W+1)'(w_p))
                                        : ((ACC_W+1)'(r_acc) + (ACC_W+1)'(w_p));
    assign w_ovfDet = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    // Choose the MAC/MSU result: two's-complement wrap, or clamp toward the true sign when saturating.
    always_comb begin
        w_accAddSub = w_sum[ACC_W-1:0];
`ifdef DSPMAC_SAT_EN
        if (w_ovfDet) begin
            w_accAddSub = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
`else
`endif
    end

    // Stage 2: update accumulator, sticky overflow and the one-cycle result-valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            case (r_op1)
                OP_CLR: begin
                    r_acc      <= '0;
                    r_ovf      <= 1'b0;
                    r_outValid <= 1'b1;
                end
                OP_MUL: begin
                    r_acc      <= w_p;
                    r_outValid <= 1'b1;
                end
                OP_MAC, OP_MSU: begin
                    r_acc      <= w_accAddSub;
                    r_outValid <= 1'b1;
                    if (w_ovfDet) begin
                        r_ovf <= 1'b1;
                    end
                end
                OP_LOAD: begin
                    r_acc      <= w_load;
                    r_outValid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = r_acc;
    assign out_valid = r_outValid;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_dspmac_pipe.sv
// tb_dspmac_pipe: random and directed stimulus for dspmac_pipe, checked against an arithmetic model.
// Two instances share the inputs: the default 40-bit accumulator and a 32-bit one that overflows easily.
module tb_dspmac_pipe;

    localparam logic [2:0] CLR  = 3'd0;
    localparam logic [2:0] MUL  = 3'd1;
    localparam logic [2:0] MAC  = 3'd2;
    localparam logic [2:0] NOP  = 3'd3;
    localparam logic [2:0] MSU  = 3'd4;
    localparam logic [2:0] LOAD = 3'd5;

`ifdef DSPMAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               inValid;
    logic [2:0]         opcode;
    logic signed [15:0] aBus;
    logic signed [15:0] bBus;
    logic signed [39:0] result40;
    logic               outValid40;
    logic               ovf40;
    logic signed [31:0] result32;
    logic               outValid32;
    logic               ovf32;

    int vectorCount = 0;
    int missCount   = 0;

    // Reference model state: per-instance accumulator, flag and valid, plus the op waiting in stage 1.
    longint     mAcc[2];
    bit         mOvf[2];
    bit         mOutValid[2];
    int         accW[2] = '{40, 32};
    bit         pValid;
    logic [2:0] pOp;
    longint     pA;
    longint     pProd;

    always #5 clk = ~clk;

    dspmac_pipe dut40 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .opcode    (opcode),
        .a_bus     (aBus),
        .b_bus     (bBus),
        .result    (result40),
        .out_valid (outValid40),
        .ovf       (ovf40)
    );

    dspmac_pipe #(.ACC_W(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .opcode    (opcode),
        .a_bus     (aBus),
        .b_bus     (bBus),
        .result    (result32),
        .out_valid (outValid32),
        .ovf       (ovf32)
    );

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint wrapTo(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= (m >>> 1)) r -= m;
        return r;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 2; i++) begin
            mAcc[i]      = 0;
            mOvf[i]      = 1'b0;
            mOutValid[i] = 1'b0;
        end
        pValid = 1'b0;
        pOp    = NOP;
        pA     = 0;
        pProd  = 0;
    endfunction

    // One clock edge of stage 2 in plain arithmetic: exact sum, then range check, then wrap or clamp.
    function automatic void modelEdge();
        for (int i = 0; i < 2; i++) begin
            longint t;
            longint hi;
            longint lo;
            hi = (longint'(1) << (accW[i] - 1)) - 1;
            lo = -(longint'(1) << (accW[i] - 1));
            mOutValid[i] = 1'b0;
            if (pValid) begin
                case (pOp)
                    CLR: begin
                        mAcc[i] = 0;
                        mOvf[i] = 1'b0;
                        mOutValid[i] = 1'b1;
                    end
                    MUL: begin
                        mAcc[i] = pProd;
                        mOutValid[i] = 1'b1;
                    end
                    MAC, MSU: begin
                        t = (pOp == MAC) ? mAcc[i] + pProd : mAcc[i] - pProd;
                        if (t > hi || t < lo) begin
                            mOvf[i] = 1'b1;
                            if (SAT) mAcc[i] = (t > hi) ? hi : lo;
                            else     mAcc[i] = wrapTo(t, accW[i]);
                        end else begin
                            mAcc[i] = t;
                        end
                        mOutValid[i] = 1'b1;
                    end
                    LOAD: begin
                        mAcc[i] = pA;
                        mOutValid[i] = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "/result40"},   result40,   mAcc[0]);
        checkOutput({tag, "/outValid40"}, outValid40, mOutValid[0]);
        checkOutput({tag, "/ovf40"},      ovf40,      mOvf[0]);
        checkOutput({tag, "/result32"},   result32,   mAcc[1]);
        checkOutput({tag, "/outValid32"}, outValid32, mOutValid[1]);
        checkOutput({tag, "/ovf32"},      ovf32,      mOvf[1]);
    endtask

    // Drive one cycle of inputs, step the model over the edge, then compare just after the edge.
    task automatic applyStimulus(input bit valid, input logic [2:0] op, input longint a,
                                 input longint b, input string tag);
        inValid = valid;
        opcode  = op;
        aBus    = a[15:0];
        bBus    = b[15:0];
        @(posedge clk);
        #1;
        modelEdge();
        pValid = valid;
        pOp    = op;
        pA     = longint'(aBus);
        pProd  = longint'(aBus) * longint'(bBus);
        checkAll(tag);
    endtask

    function automatic longint pickOperand();
        case ($urandom_range(0, 3))
            0:       return ($urandom_range(0, 1) == 0) ? 32767 : -32768;
            default: return longint'($signed(16'($urandom)));
        endcase
    endfunction

    initial begin
        rst_n   = 1'b0;
        inValid = 1'b0;
        opcode  = CLR;
        aBus    = '0;
        bBus    = '0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkAll("inReset");
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, CLR, 0, 0, "idleAfterReset");

        applyStimulus(1'b1, MUL, 32767, 32767, "mulMax");
        applyStimulus(1'b1, MAC, 32767, 32767, "macMax1");
        checkOutput("planMul40", result40, 64'sd1073676289);
        applyStimulus(1'b1, MAC, 32767, 32767, "macMax2");
        checkOutput("planMac40", result40, 64'sd2147352578);
        checkOutput("planMac32", result32, 64'sd2147352578);
        applyStimulus(1'b0, NOP, 0, 0, "drainMax");
        checkOutput("planThird40", result40, 64'sd3221028867);
        checkOutput("planThird32", result32, SAT ? 64'sd2147483647 : -64'sd1073938429);
        checkOutput("planOvf32", ovf32, 64'sd1);
        checkOutput("planOvf40", ovf40, 64'sd0);
        applyStimulus(1'b1, CLR, 0, 0, "clrAfterOvf");
        applyStimulus(1'b0, NOP, 0, 0, "clrDrain");
        checkOutput("planClr32", result32, 64'sd0);
        checkOutput("planClrOvf32", ovf32, 64'sd0);

        applyStimulus(1'b1, MUL, -32768, 32767, "mulNeg");
        applyStimulus(1'b1, MSU, -32768, -32768, "msuNeg");
        checkOutput("planMulNeg", result40, -64'sd1073709056);
        applyStimulus(1'b0, NOP, 0, 0, "msuDrain");
        checkOutput("planMsuNeg", result40, -64'sd2147450880);

        applyStimulus(1'b1, LOAD, -5, 0, "load");
        applyStimulus(1'b1, MAC, 3, 4, "macSmall");
        checkOutput("planLoad", result40, -64'sd5);
        applyStimulus(1'b0, MAC, 3, 4, "invalidMac1");
        checkOutput("planMacSmall", result40, 64'sd7);
        applyStimulus(1'b0, MAC, 3, 4, "invalidMac2");
        checkOutput("planHold", result40, 64'sd7);
        checkOutput("planHoldValid", outValid40, 64'sd0);

        for (int i = 0; i < 400; i++) begin
            bit         v;
            logic [2:0] op;
            v  = ($urandom_range(0, 7) != 0);
            op = 3'($urandom_range(0, 7));
            applyStimulus(v, op, pickOperand(), pickOperand(), "random");
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, MAC, 32767, 32767, "macStream");
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("asyncReset");
        checkOutput("asyncResetResult", result40, 64'sd0);
        inValid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, NOP, 0, 0, "postResetNop");
        applyStimulus(1'b1, MUL, 2, 3, "postResetMul");
        applyStimulus(1'b0, NOP, 0, 0, "postResetDrain");
        checkOutput("planPostReset", result40, 64'sd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/dspmac_pipe.md
# dspmac_pipe

Parametrised, pipelined signed multiply-accumulate unit; next-generation successor to the fixed 16×16/40-bit MAC. Adds configurable operand and accumulator widths, an input-valid/output-valid handshake, multiply-subtract and accumulator-load operations, and a sticky overflow flag with optional saturation. Sits in the DSP datapath between operand buses and the result bus; one operation accepted per clock, no stalls.

## Interface
- `A_W`, 16: width of signed operand `a_bus`.
- `B_W`, 16: width of signed operand `b_bus`.
- `ACC_W`, 40: accumulator/result width. Must be ≥ `A_W+B_W`; violation is an elaboration error.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  qualifies `opcode`/`a_bus`/`b_bus`; low is treated as NOP.
- `opcode`  in  3  000 CLR, 001 MUL, 010 MAC, 011 NOP, 100 MSU, 101 LOAD, 110/111 NOP.
- `a_bus`  in  `A_W`  signed operand A.
- `b_bus`  in  `B_W`  signed operand B.
- `result`  out  `ACC_W`  signed accumulator value (registered).
- `out_valid`  out  1  one-cycle pulse: `result` updated by a non-NOP op this cycle.
- `ovf`  out  1  sticky overflow flag.

## Operation
- Stage 1 (edge k): if `in_valid`, register `p1 = a_bus*b_bus` (full `A_W+B_W` signed), `op1 = opcode`, `a1 = a_bus`; else `op1 = NOP`.
- Stage 2 (edge k+1), `p` = `p1` sign-extended to `ACC_W`:
  - CLR: acc = 0, ovf = 0.
  - MUL: acc = p.
  - MAC: acc = acc + p.
  - MSU: acc = acc − p.
  - LOAD: acc = `a1` sign-extended to `ACC_W`.
  - NOP / 110 / 111: acc and ovf hold.
- MAC/MSU computed in `ACC_W+1` bits; overflow when the top two bits of the sum differ. On overflow `ovf` sets and stays set until CLR or reset.
- MUL and LOAD cannot overflow (width rule) and never touch `ovf`.
- `out_valid` = 1 in the cycle after stage 2 processes any op except NOP/110/111 (including CLR).
- Back-to-back MAC/MSU every cycle: accumulator feedback is single-cycle, no hazard.

## Timing
- Reset values: `result` = 0, `out_valid` = 0, `ovf` = 0, `op1` = NOP, `p1` = 0, `a1` = 0.
- Latency 2: op presented with `in_valid` before edge k is reflected on `result` after edge k+1.
- Throughput 1 op/cycle; no backpressure.
- `rst_n` low mid-operation: all state clears immediately (asynchronous); ops in flight are discarded; first op after release obeys normal latency.
- CLR and overflow in the same stage-2 cycle cannot occur (one op per cycle); CLR always wins over prior sticky `ovf`.

## Configuration
- `DSPMAC_SAT_EN` defined: on MAC/MSU overflow, acc clamps to +2^(ACC_W−1)−1 (positive overflow) or −2^(ACC_W−1) (negative overflow); `ovf` sets.
- Not defined: acc wraps modulo 2^ACC_W (two's complement); `ovf` still sets.

## Test plan
- Reset with `opcode`=CLR, release `rst_n`, hold `in_valid`=0 → `result`=0, `out_valid`=0, `ovf`=0 throughout.
- Defaults; a=b=32767: MUL then MAC on consecutive cycles → `result`=1073676289 two edges after MUL, then 2147352578 one edge later; `out_valid` high for both cycles; `ovf`=0.
- a=−32768, b=32767, MUL, then a=b=−32768 MSU → `result`=−1073709056, then −2147450880.
- LOAD a=−5, then MAC a=3, b=4 → `result`=−5, then 7; drop `in_valid` with `opcode`=MAC → `result` holds 7, `out_valid`=0.
- `ACC_W`=32, a=b=32767: MUL, MAC, MAC → with `DSPMAC_SAT_EN`, 1073676289, 2147352578, 2147483647, `ovf`=1; without, third value −1073938429, `ovf`=1; following CLR → `result`=0, `ovf`=0.
- MAC stream in flight, assert `rst_n`=0 mid-cycle → `result`, `out_valid`, `ovf` go 0 before the next edge; after release, one NOP cycle then MUL 2×3 → `result`=6 after 2 edges.
